pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with one skid entry, so the upstream ready never depends
// combinationally on the downstream ready. Supports flush (redirect) and a masked bubble control.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,

    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    logic accept;
    logic pop;

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            // Redirect: drop everything, including an entry offered this cycle.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d     = StOne;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                StOne: begin
                    if (accept && !pop) begin
                        state_d     = StFull;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (pop && !accept) begin
                        state_d = StEmpty;
                    end else if (accept && pop) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                StFull: begin
                    if (pop) begin
                        state_d     = StOne;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end

        // Registered ready: computed from the next state so it is valid the cycle it is needed.
        in_ready_d = (state_d != StFull);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : BUBBLE_CTRL;

    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            StEmpty: occupancy = 2'd0;
            StOne:   occupancy = 2'd1;
            StFull:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule
